// File: rtl/rsa_pkg.sv
// ============================================================================
// Package : rsa_pkg -- shared FSM states and sizing for the mod-exp core
// Rev     : 1.0
// ============================================================================
`default_nettype none

package rsa_pkg;

  localparam int DEFAULT_WIDTH = 256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    REDUCE = 3'd2,
    SCAN   = 3'd3,
    SQUARE = 3'd4,
    MULT   = 3'd5,
    NEXT   = 3'd6,
    DONE   = 3'd7
  } state_e;

  function automatic int MULT_LAT(input int width);
    return width + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_mult_serial.sv
// ============================================================================
// Module : mod_mult_serial -- bit-serial interleaved modular multiplier, p = a*b mod n
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mod_mult_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             done_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int CW = $clog2(MULT_LAT(WIDTH));
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_LAT(WIDTH) - 1);

  logic [WIDTH-1:0] a_q, b_q, n_q, p_q, p_d;
  logic [CW-1:0]    cnt_q;
  logic             active_q;
  logic [WIDTH+1:0] acc_sum, acc_red;

  // With p < n and b < n, 2p + b < 3n, so two conditional subtractions restore p < n.
  always_comb begin
    acc_sum = {1'b0, p_q, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
    acc_red = (acc_sum >= {2'b00, n_q}) ? acc_sum - {2'b00, n_q} : acc_sum;
    p_d     = (acc_red >= {2'b00, n_q}) ? WIDTH'(acc_red - {2'b00, n_q}) : WIDTH'(acc_red);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      a_q      <= a_i;
      b_q      <= b_i;
      n_q      <= n_i;
      p_q      <= '0;
      cnt_q    <= CNT_LOAD;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        p_q   <= p_d;
        a_q   <= a_q << 1;
        cnt_q <= cnt_q - CW'(1);
      end else begin
        active_q <= 1'b0;
      end
    end
  end

  assign done_o = active_q && (cnt_q == '0);
  assign p_o    = p_q;

endmodule

`default_nettype wire

// File: rtl/rsa_mod_exp_core.sv
// ============================================================================
// Module : rsa_mod_exp_core -- left-to-right square-and-multiply, result = base^exponent mod modulus
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rsa_mod_exp_core
  import rsa_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     base_i,
  input  logic [EXP_WIDTH-1:0] exponent_i,
  input  logic [WIDTH-1:0]     modulus_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [WIDTH-1:0]     result_o
);

  localparam int CW = $clog2(EXP_WIDTH + 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     base_q, base_d, mod_q, mod_d, acc_q, acc_d;
  logic [WIDTH-1:0]     bred_q, bred_d, result_q, result_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 error_q, error_d;

  logic                 mult_start, mult_done;
  logic [WIDTH-1:0]     mult_a, mult_b, mult_p;

  mod_mult_serial #(.WIDTH(WIDTH)) u_mult (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (mult_start),
    .a_i     (mult_a),
    .b_i     (mult_b),
    .n_i     (mod_q),
    .done_o  (mult_done),
    .p_o     (mult_p)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    mod_d      = mod_q;
    acc_d      = acc_q;
    bred_d     = bred_q;
    result_d   = result_q;
    exp_d      = exp_q;
    cnt_d      = cnt_q;
    error_d    = error_q;
    mult_start = 1'b0;
    mult_a     = acc_q;
    mult_b     = acc_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d  = base_i;
          exp_d   = exponent_i;
          mod_d   = modulus_i;
          error_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        cnt_d = CW'(EXP_WIDTH - 1);
        if (mod_q == '0) begin
          error_d  = 1'b1;
          result_d = '0;
          state_d  = DONE;
        end else if (mod_q == WIDTH'(1)) begin
          result_d = '0;
          state_d  = DONE;
        end else if (exp_q == '0) begin
          result_d = WIDTH'(1);
          state_d  = DONE;
        end else begin
          mult_start = 1'b1;
          mult_a     = base_q;
          mult_b     = WIDTH'(1);
          state_d    = REDUCE;
        end
      end
      REDUCE: begin
        if (mult_done) begin
          bred_d  = mult_p;
          state_d = SCAN;
        end
      end
      // The cycle that finds the leading one also consumes it, so the counter
      // then holds the number of bits still to process.
      SCAN: begin
        if (!exp_q[EXP_WIDTH-1]) begin
          exp_d = exp_q << 1;
          cnt_d = cnt_q - CW'(1);
        end else begin
          acc_d = bred_q;
          if (cnt_q == '0) begin
            result_d = bred_q;
            state_d  = DONE;
          end else begin
            cnt_d      = cnt_q - CW'(1);
            exp_d      = exp_q << 1;
            mult_start = 1'b1;
            mult_a     = bred_q;
            mult_b     = bred_q;
            state_d    = SQUARE;
          end
        end
      end
      SQUARE: begin
        if (mult_done) begin
          acc_d = mult_p;
          if (exp_q[EXP_WIDTH-1]) begin
            mult_start = 1'b1;
            mult_a     = mult_p;
            mult_b     = bred_q;
            state_d    = MULT;
          end else begin
            state_d = NEXT;
          end
        end
      end
      MULT: begin
        if (mult_done) begin
          acc_d   = mult_p;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (cnt_q == '0) begin
          result_d = acc_q;
          state_d  = DONE;
        end else begin
          cnt_d      = cnt_q - CW'(1);
          exp_d      = exp_q << 1;
          mult_start = 1'b1;
          mult_a     = acc_q;
          mult_b     = acc_q;
          state_d    = SQUARE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      base_q   <= '0;
      mod_q    <= '0;
      acc_q    <= '0;
      bred_q   <= '0;
      result_q <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      mod_q    <= mod_d;
      acc_q    <= acc_d;
      bred_q   <= bred_d;
      result_q <= result_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign error_o  = error_q;
  assign result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_rsa_mod_exp_core.sv
// ============================================================================
// Module : tb_rsa_mod_exp_core -- self-checking bench for rsa_mod_exp_core (16-bit and 256-bit builds)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rsa_mod_exp_core;

  logic clk;
  logic rst;

  logic         start16, rdy16, busy16, done16, err16;
  logic [15:0]  base16, exp16, mod16, res16;

  logic         start256, rdy256, busy256, done256, err256;
  logic [255:0] base256, mod256, res256;
  logic [11:0]  exp256;

  int checks;
  int errors;

  rsa_mod_exp_core #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (
    .clk_i(clk), .reset_i(rst), .start_i(start16), .base_i(base16), .exponent_i(exp16),
    .modulus_i(mod16), .ready_o(rdy16), .busy_o(busy16), .done_o(done16),
    .error_o(err16), .result_o(res16)
  );

  rsa_mod_exp_core #(.WIDTH(256), .EXP_WIDTH(12)) dut256 (
    .clk_i(clk), .reset_i(rst), .start_i(start256), .base_i(base256), .exponent_i(exp256),
    .modulus_i(mod256), .ready_o(rdy256), .busy_o(busy256), .done_o(done256),
    .error_o(err256), .result_o(res256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] b;
    logic [15:0] e;
    logic [15:0] n;
    logic [15:0] r;
    logic        err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Right-to-left binary exponentiation on wide integers.
  function automatic logic [255:0] ref_pow(input logic [255:0] b, input logic [255:0] e,
                                           input logic [255:0] n);
    logic [511:0] r, x, nn;
    if (n == 0) return '0;
    nn = {256'd0, n};
    r  = 512'd1 % nn;
    x  = {256'd0, b} % nn;
    while (e != 0) begin
      if (e[0]) r = (r * x) % nn;
      x = (x * x) % nn;
      e = e >> 1;
    end
    return r[255:0];
  endfunction

  function automatic int ref_lat(input logic [255:0] e, input logic [255:0] n,
                                 input int width, input int ew);
    int msb, ones;
    if (n < 2 || e == 0) return 1;
    msb  = 0;
    ones = 0;
    for (int i = 0; i < ew; i++) begin
      if (e[i]) begin
        msb = i;
        ones++;
      end
    end
    return 2 + (width + 1) * (1 + msb + (ones - 1)) + (ew - 1 - msb) + msb;
  endfunction

  task automatic op16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] n,
                      output logic [15:0] res, output logic err, output int lat);
    int guard;
    guard = 0;
    while (!rdy16 && guard < 5000) begin @(negedge clk); guard++; end
    base16 = b; exp16 = e; mod16 = n; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 5000) begin @(negedge clk); lat++; end
    res = res16;
    err = err16;
  endtask

  task automatic op256(input logic [255:0] b, input logic [11:0] e, input logic [255:0] n,
                       output logic [255:0] res, output logic err, output int lat);
    int guard;
    guard = 0;
    while (!rdy256 && guard < 20000) begin @(negedge clk); guard++; end
    base256 = b; exp256 = e; mod256 = n; start256 = 1'b1;
    @(negedge clk);
    start256 = 1'b0;
    lat = 0;
    while (!done256 && lat < 20000) begin @(negedge clk); lat++; end
    res = res256;
    err = err256;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  r16;
    logic [255:0] r256, b256, n256;
    logic [15:0]  b, e, n;
    logic [11:0]  e12;
    logic         er;
    int           lat, guard, dones;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    start16 = 1'b0; base16 = '0; exp16 = '0; mod16 = '0;
    start256 = 1'b0; base256 = '0; exp256 = '0; mod256 = '0;

    tbl[0] = '{16'd4,    16'd13,    16'd497,  16'd445,  1'b0};
    tbl[1] = '{16'd65,   16'd17,    16'd3233, 16'd2790, 1'b0};
    tbl[2] = '{16'd2790, 16'd2753,  16'd3233, 16'd65,   1'b0};
    tbl[3] = '{16'd7,    16'd0,     16'd13,   16'd1,    1'b0};
    tbl[4] = '{16'd5,    16'd9,     16'd1,    16'd0,    1'b0};
    tbl[5] = '{16'd9,    16'd5,     16'd0,    16'd0,    1'b1};
    tbl[6] = '{16'd20,   16'd3,     16'd7,    16'd6,    1'b0};
    tbl[7] = '{16'd3,    16'd1,     16'd11,   16'd3,    1'b0};
    tbl[8] = '{16'd2,    16'd10,    16'd1000, 16'd24,   1'b0};
    tbl[9] = '{16'd0,    16'hFFFF,  16'd13,   16'd0,    1'b0};

    repeat (3) @(negedge clk);
    chk("reset_ready",  256'(rdy16),  256'(1));
    chk("reset_busy",   256'(busy16), 256'(0));
    chk("reset_done",   256'(done16), 256'(0));
    chk("reset_error",  256'(err16),  256'(0));
    chk("reset_result", 256'(res16),  256'(0));
    chk("reset_ready256", 256'(rdy256), 256'(1));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      op16(tbl[i].b, tbl[i].e, tbl[i].n, r16, er, lat);
      chk($sformatf("tbl%0d_result", i), 256'(r16), 256'(tbl[i].r));
      chk($sformatf("tbl%0d_error", i),  256'(er),  256'(tbl[i].err));
      chk($sformatf("tbl%0d_latency", i), 256'(lat),
          256'(ref_lat(256'(tbl[i].e), 256'(tbl[i].n), 16, 16)));
      @(negedge clk);
      chk($sformatf("tbl%0d_done_width", i), 256'(done16), 256'(0));
    end

    for (int i = 0; i < 8; i++) begin
      b = 16'($urandom);
      e = 16'($urandom);
      n = 16'($urandom_range(65535, 2));
      op16(b, e, n, r16, er, lat);
      chk($sformatf("rnd16_%0d_result", i), 256'(r16), ref_pow(256'(b), 256'(e), 256'(n)));
      chk($sformatf("rnd16_%0d_latency", i), 256'(lat), 256'(ref_lat(256'(e), 256'(n), 16, 16)));
    end

    // start pulsed while busy is ignored; start then held high across done
    guard = 0;
    while (!rdy16 && guard < 100) begin @(negedge clk); guard++; end
    base16 = 16'd65; exp16 = 16'd17; mod16 = 16'd3233; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (10) @(negedge clk);
    base16 = 16'd2; exp16 = 16'd3; mod16 = 16'd5; start16 = 1'b1;
    @(negedge clk);
    base16 = 16'd4; exp16 = 16'd13; mod16 = 16'd497;
    guard = 0;
    while (!done16 && guard < 5000) begin @(negedge clk); guard++; end
    chk("busy_pulse_result", 256'(res16), 256'(2790));
    chk("held_not_ready_at_done", 256'(rdy16), 256'(0));
    @(negedge clk);
    chk("held_ready_after_done", 256'(rdy16), 256'(1));
    @(negedge clk);
    start16 = 1'b0;
    chk("held_start_accepted", 256'(busy16), 256'(1));
    lat = 0;
    while (!done16 && lat < 5000) begin @(negedge clk); lat++; end
    chk("held_result", 256'(res16), 256'(445));
    chk("held_latency", 256'(lat), 256'(ref_lat(256'(13), 256'(497), 16, 16)));
    dones = 0;
    repeat (30) begin @(negedge clk); if (done16) dones++; end
    chk("held_single_accept", 256'(dones), 256'(0));

    // asynchronous reset in the middle of a squaring pass
    base16 = 16'd65; exp16 = 16'd17; mod16 = 16'd3233; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (35) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready",  256'(rdy16),  256'(1));
    chk("async_rst_busy",   256'(busy16), 256'(0));
    chk("async_rst_done",   256'(done16), 256'(0));
    chk("async_rst_result", 256'(res16),  256'(0));
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (40) begin @(negedge clk); if (done16) dones++; end
    chk("async_rst_no_done", 256'(dones), 256'(0));
    op16(16'd4, 16'd13, 16'd497, r16, er, lat);
    chk("after_rst_result", 256'(r16), 256'(445));

    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < 8; w++) begin
        b256[w*32 +: 32] = $urandom;
        n256[w*32 +: 32] = $urandom;
      end
      n256[255] = 1'b1;
      n256[0]   = 1'b1;
      e12 = (i == 5) ? 12'hFFF : 12'($urandom_range(4095, 1));
      op256(b256, e12, n256, r256, er, lat);
      chk($sformatf("w256_%0d_result", i), r256, ref_pow(b256, 256'(e12), n256));
      chk($sformatf("w256_%0d_error", i), 256'(er), 256'(0));
      chk($sformatf("w256_%0d_latency", i), 256'(lat), 256'(ref_lat(256'(e12), n256, 256, 12)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
